// File: rtl/snn_if_layer.sv
// snn_if_layer: integrate-and-fire spiking layer with N_OUT neurons fully connected to N_IN binary inputs.
// A timestep pulse latches the input spikes. The layer then walks the inputs one per clock,
// accumulating weights for all neurons in parallel, and finally updates and thresholds each membrane.
// Optional feature macro: SNN_LEAK_EN. When defined, the update applies the leak v - (v >>> LEAK_SHIFT).
module snn_if_layer #(
    parameter int unsigned N_IN       = 5,
    parameter int unsigned N_OUT      = 2,
    parameter int unsigned W_W        = 8,
    parameter int unsigned POT_W      = 16,
    parameter int unsigned THRESH     = 64,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pulse,
    input  logic [N_IN-1:0]             pixels_in,
    input  logic [N_OUT*N_IN*W_W-1:0]   weights_in,
    input  logic [N_OUT*W_W-1:0]        bias_in,
    output logic [N_OUT-1:0]            spike,
    output logic                        spike_valid,
    output logic                        busy,
    output logic                        overrun
);

    localparam int unsigned K_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned SUM_W = POT_W + 2;

    localparam logic [K_W-1:0]          K_LAST   = K_W'(N_IN - 1);
    localparam logic signed [SUM_W-1:0] POT_MAX  = {2'b00, 1'b0, {(POT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] POT_MIN  = {2'b11, 1'b1, {(POT_W-1){1'b0}}};
    localparam logic signed [POT_W-1:0] THRESH_V = POT_W'(THRESH);

    // Reject parameter sets that would let the accumulator or threshold overflow.
    if ((POT_W < W_W + $clog2(N_IN) + 1) || (THRESH == 0) ||
        (longint'(THRESH) >= (longint'(1) << (POT_W - 1))) || (LEAK_SHIFT >= POT_W))
    begin : g_param_check
        $error("snn_if_layer: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_UPDATE
    } state_t;

    state_t                    state_q;
    logic [N_IN-1:0]           shadow_q;
    logic [K_W-1:0]            k_q;
    logic signed [POT_W-1:0]   acc_q [N_OUT];
    logic signed [POT_W-1:0]   v_q   [N_OUT];
    logic [N_OUT-1:0]          spike_q;
    logic                      spike_valid_q;
    logic                      busy_q;
    logic                      overrun_q;

    logic signed [W_W-1:0]     w_cur [N_OUT];
    logic signed [W_W-1:0]     b_cur [N_OUT];
    logic signed [POT_W-1:0]   acc_d [N_OUT];
    logic signed [SUM_W-1:0]   v_base [N_OUT];
    logic signed [SUM_W-1:0]   v_sum  [N_OUT];
    logic signed [POT_W-1:0]   v_sat  [N_OUT];
    logic signed [POT_W-1:0]   v_d    [N_OUT];
    logic [N_OUT-1:0]          fire_d;

    // Select the live weight for the current input index and the bias of each neuron.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            w_cur[j] = weights_in[(j*N_IN + int'(k_q))*W_W +: W_W];
            b_cur[j] = bias_in[j*W_W +: W_W];
        end
    end

    // Accumulate the current input's weight when its latched spike is set.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            acc_d[j] = acc_q[j];
            if (shadow_q[k_q]) begin
                acc_d[j] = acc_q[j] + POT_W'(w_cur[j]);
            end
        end
    end

    // Membrane update: optional leak, add accumulator and bias, saturate, threshold with subtractive reset.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
`ifdef SNN_LEAK_EN
            v_base[j] = SUM_W'(v_q[j]) - SUM_W'(v_q[j] >>> LEAK_SHIFT);
`else
            v_base[j] = SUM_W'(v_q[j]);
`endif
            v_sum[j] = v_base[j] + SUM_W'(acc_d[j]) + SUM_W'(b_cur[j]);
            if (v_sum[j] > POT_MAX) begin
                v_sat[j] = POT_W'(POT_MAX);
            end else if (v_sum[j] < POT_MIN) begin
                v_sat[j] = POT_W'(POT_MIN);
            end else begin
                v_sat[j] = POT_W'(v_sum[j]);
            end
            fire_d[j] = (v_sat[j] >= THRESH_V);
            v_d[j]    = fire_d[j] ? (v_sat[j] - THRESH_V) : v_sat[j];
        end
    end

    // Control FSM and datapath registers. The membrane update is registered on the
    // last ACC edge, so UPDATE is the cycle in which the new spike vector is presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            shadow_q      <= '0;
            k_q           <= '0;
            spike_q       <= '0;
            spike_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                acc_q[j] <= '0;
                v_q[j]   <= '0;
            end
        end else begin
            spike_valid_q <= 1'b0;
            if (pulse && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (pulse) begin
                        shadow_q <= pixels_in;
                        k_q      <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_ACC;
                        for (int j = 0; j < N_OUT; j++) begin
                            acc_q[j] <= '0;
                        end
                    end
                end
                S_ACC: begin
                    k_q <= k_q + K_W'(1);
                    for (int j = 0; j < N_OUT; j++) begin
                        acc_q[j] <= acc_d[j];
                    end
                    if (k_q == K_LAST) begin
                        for (int j = 0; j < N_OUT; j++) begin
                            v_q[j] <= v_d[j];
                        end
                        spike_q       <= fire_d;
                        spike_valid_q <= 1'b1;
                        state_q       <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign spike       = spike_q;
    assign spike_valid = spike_valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_snn_if_layer.sv
// Bench for snn_if_layer: directed timestep scenarios plus randomized steps
// checked against a behavioural integrate-and-fire model.
module tb_snn_if_layer;

    localparam int N_IN       = 5;
    localparam int N_OUT      = 2;
    localparam int W_W        = 8;
    localparam int POT_W      = 16;
    localparam int THRESH     = 64;
    localparam int LEAK_SHIFT = 3;
    localparam int V_HI       = (1 << (POT_W - 1)) - 1;
    localparam int V_LO       = -(1 << (POT_W - 1));

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      pulse;
    logic [N_IN-1:0]           pixels_in;
    logic [N_OUT*N_IN*W_W-1:0] weights_in;
    logic [N_OUT*W_W-1:0]      bias_in;
    logic [N_OUT-1:0]          spike;
    logic                      spike_valid;
    logic                      busy;
    logic                      overrun;

    int checks   = 0;
    int failures = 0;

    int               w_m [N_OUT][N_IN];
    int               b_m [N_OUT];
    int               v_m [N_OUT];
    logic [N_OUT-1:0] spike_m;

    snn_if_layer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .W_W(W_W), .POT_W(POT_W),
        .THRESH(THRESH), .LEAK_SHIFT(LEAK_SHIFT)
    ) dut (
        .clk(clk), .reset(reset), .pulse(pulse), .pixels_in(pixels_in),
        .weights_in(weights_in), .bias_in(bias_in), .spike(spike),
        .spike_valid(spike_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_params;
        for (int j = 0; j < N_OUT; j++) begin
            for (int k = 0; k < N_IN; k++) begin
                weights_in[(j*N_IN + k)*W_W +: W_W] = W_W'(w_m[j][k]);
            end
            bias_in[j*W_W +: W_W] = W_W'(b_m[j]);
        end
    endtask

    function automatic int rnd_w();
        return int'($urandom_range(255)) - 128;
    endfunction

    // Reference: one timestep of integrate-and-fire from the behavioural rules.
    task automatic model_step(input logic [N_IN-1:0] pix);
        for (int j = 0; j < N_OUT; j++) begin
            int acc;
            int v;
            acc = 0;
            for (int k = 0; k < N_IN; k++) begin
                if (pix[k]) acc += w_m[j][k];
            end
            v = v_m[j];
`ifdef SNN_LEAK_EN
            v = v - (v >>> LEAK_SHIFT);
`endif
            v = v + acc + b_m[j];
            if (v > V_HI) v = V_HI;
            if (v < V_LO) v = V_LO;
            if (v >= THRESH) begin
                spike_m[j] = 1'b1;
                v = v - THRESH;
            end else begin
                spike_m[j] = 1'b0;
            end
            v_m[j] = v;
        end
    endtask

    task automatic check_state(input string tag);
        for (int j = 0; j < N_OUT; j++) begin
            check($sformatf("%s_spike%0d", tag, j), longint'(spike[j]), longint'(spike_m[j]));
            check($sformatf("%s_v%0d", tag, j), longint'(dut.v_q[j]), longint'(v_m[j]));
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_spike"}, longint'(spike), 0);
        check({tag, "_sv"}, longint'(spike_valid), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_ovr"}, longint'(overrun), 0);
        for (int j = 0; j < N_OUT; j++) begin
            check($sformatf("%s_v%0d", tag, j), longint'(dut.v_q[j]), 0);
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check_reset_outs(tag);
        tick;
        reset = 1'b0;
        for (int j = 0; j < N_OUT; j++) v_m[j] = 0;
        spike_m = '0;
    endtask

    // One timestep; 'late' > 0 raises an extra pulse in cycle T+late.
    task automatic run_step(input logic [N_IN-1:0] pix, input string tag, input int late);
        int n;
        pixels_in = pix;
        pulse     = 1'b1;
        tick;
        pulse     = 1'b0;
        pixels_in = N_IN'($urandom);
        check({tag, "_busy_acc"}, longint'(busy), 1);
        n = 1;
        while (spike_valid !== 1'b1 && n <= N_IN + 4) begin
            if (n == late) pulse = 1'b1;
            tick;
            pulse = 1'b0;
            n++;
        end
        check({tag, "_latency"}, longint'(n), longint'(N_IN + 1));
        check({tag, "_busy_sv"}, longint'(busy), 1);
        model_step(pix);
        check_state(tag);
        if (n == late) pulse = 1'b1;
        tick;
        pulse = 1'b0;
        check({tag, "_sv_drop"}, longint'(spike_valid), 0);
        check({tag, "_busy_drop"}, longint'(busy), 0);
    endtask

    initial begin
        int sv_seen;
        reset      = 1'b1;
        pulse      = 1'b0;
        pixels_in  = '0;
        for (int j = 0; j < N_OUT; j++) begin
            for (int k = 0; k < N_IN; k++) w_m[j][k] = rnd_w();
            b_m[j] = rnd_w();
            v_m[j] = 0;
        end
        spike_m = '0;
        drive_params();
        tick;
        tick;
        check_reset_outs("init");
        reset = 1'b0;
        tick;

        // Two-input integration reaching threshold on the second step.
        for (int k = 0; k < N_IN; k++) w_m[0][k] = 20;
        b_m[0] = 0;
        drive_params();
        run_step(5'b00011, "t2a", 0);
        check("t2a_v0_const", longint'(dut.v_q[0]), 40);
        check("t2a_spk0_const", longint'(spike[0]), 0);
        run_step(5'b00011, "t2b", 0);
        check("t2b_v0_const", longint'(dut.v_q[0]), 16);
        check("t2b_spk0_const", longint'(spike[0]), 1);
        check("t2_ovr", longint'(overrun), 0);

        // Pulse during ACC is ignored and sets sticky overrun.
        run_step(N_IN'($urandom), "t3a", 3);
        check("t3a_ovr", longint'(overrun), 1);
        run_step(N_IN'($urandom), "t3b", 0);
        check("t3b_ovr_sticky", longint'(overrun), 1);

        // Pulse coincident with spike_valid is also ignored.
        do_reset("t3r");
        run_step(N_IN'($urandom), "t3c", N_IN + 1);
        check("t3c_ovr", longint'(overrun), 1);

        // Negative saturation: large negative weights and bias, all inputs active.
        do_reset("t4r");
        for (int k = 0; k < N_IN; k++) w_m[1][k] = -128;
        b_m[1] = -128;
        drive_params();
        for (int i = 0; i < 45; i++) begin
            run_step(5'h1F, $sformatf("t4_%0d", i), 0);
            if (i == 42) check("t4_v1_sat", longint'(dut.v_q[1]), longint'(V_LO));
        end
        check("t4_v1_end", longint'(dut.v_q[1]), longint'(V_LO));

        // Asynchronous reset in the third ACC cycle aborts the integration.
        do_reset("t5r");
        for (int j = 0; j < N_OUT; j++) begin
            for (int k = 0; k < N_IN; k++) w_m[j][k] = rnd_w();
            b_m[j] = rnd_w();
        end
        drive_params();
        run_step(N_IN'($urandom), "t5pre", 0);
        pixels_in = 5'h1F;
        pulse     = 1'b1;
        tick;
        pulse     = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        #1;
        check_reset_outs("t5_mid");
        tick;
        reset = 1'b0;
        for (int j = 0; j < N_OUT; j++) v_m[j] = 0;
        spike_m = '0;
        sv_seen = 0;
        for (int i = 0; i < N_IN + 3; i++) begin
            tick;
            if (spike_valid === 1'b1) sv_seen++;
        end
        check("t5_no_sv", longint'(sv_seen), 0);
        run_step(N_IN'($urandom), "t5post", 0);

        // Quiet timestep: membrane holds, or leaks when the leak feature is built in.
        do_reset("t6r");
        for (int k = 0; k < N_IN; k++) w_m[0][k] = 20;
        b_m[0] = 0;
        drive_params();
        run_step(5'b00011, "t6a", 0);
        run_step(5'b00000, "t6b", 0);
`ifdef SNN_LEAK_EN
        check("t6_v0_const", longint'(dut.v_q[0]), 35);
`else
        check("t6_v0_const", longint'(dut.v_q[0]), 40);
`endif
        check("t6_spk0_const", longint'(spike[0]), 0);

        // Randomized timesteps with fresh weights and biases each step.
        do_reset("rndr");
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < N_OUT; j++) begin
                for (int k = 0; k < N_IN; k++) w_m[j][k] = rnd_w();
                b_m[j] = rnd_w();
            end
            drive_params();
            run_step(N_IN'($urandom), $sformatf("rnd_%0d", i), 0);
            if ($urandom_range(3) == 0) tick;
        end
        check("rnd_ovr", longint'(overrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
